regfile_write_arbiter: RTL and testbench

Shares the single write port of register_file between two writeback sources: requester 0 (ALU result) and requester 1 (load/immediate path).
- Each requester has a valid/ready handshake.
- Contention is resolved round-robin.
- The winning write is registered and driven onto we/waddr/wdata of register_file one cycle later.
- Writes to non-writable addresses (4-7) are dropped and counted, so the regfile write port only ever sees legal traffic.

---
 rtl/regfile_write_arbiter_pkg.sv | 25 ++
 rtl/regfile_write_arbiter_if.sv | 36 +++
 rtl/rr_arbiter2.sv | 42 ++++
 rtl/regfile_write_arbiter.sv | 82 ++++++++
 tb/tb_regfile_write_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds data/address widths, the writable-range limit and the request bundle.
package regfile_write_arbiter_pkg;

    localparam int DATA_W       = 10;
    localparam int ADDR_W       = 3;
    localparam int NUM_WRITABLE = 4;
    localparam int CNT_W        = 8;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NUM_WRITABLE;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the two writeback sources, the arbiter and the regfile.
// master: requesters/regfile side (drives valids, sees readies); slave: arbiter.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W,
    parameter int CW = CNT_W
);
    logic          hold;
    logic          valid0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic          ready0;
    logic          valid1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic          ready1;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          err;
    logic          err_clr;
    logic [CW-1:0] drop_cnt;

    modport master (
        output hold, valid0, addr0, data0, valid1, addr1, data1, err_clr,
        input  ready0, ready1, rf_we, rf_waddr, rf_wdata, err, drop_cnt
    );

    modport slave (
        input  hold, valid0, addr0, data0, valid1, addr1, data1, err_clr,
        output ready0, ready1, rf_we, rf_waddr, rf_wdata, err, drop_cnt
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
// Ports: req[1:0], advance (a grant was consumed), hold -> gnt[1:0], rr_ptr.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       hold,
    output logic [1:0] gnt,
    output req_idx_t   rr_ptr
);

    req_idx_t ptr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= REQ0;
        end else begin
            rr_ptr <= ptr_next;
        end
    end

    always_comb begin
        gnt      = 2'b00;
        ptr_next = rr_ptr;
        if (!hold) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_ptr == REQ1) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
        // Favour whoever lost this round.
        if (advance && (gnt != 2'b00)) begin
            ptr_next = gnt[0] ? REQ1 : REQ0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between requester 0 (ALU) and 1 (load/imm).
// Ports: clk, rst, bus (slave): handshakes in, registered rf_we/waddr/wdata, err/drop_cnt out.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    regfile_write_arbiter_if.slave bus
);

    wb_req_t    r0;
    wb_req_t    r1;
    wb_req_t    win;
    logic [1:0] gnt;
    logic       xfer;
    logic       wr_ok;
    logic       drop;
    req_idx_t   unused_rr_ptr;

    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    assign r0 = '{valid: bus.valid0, addr: bus.addr0, data: bus.data0};
    assign r1 = '{valid: bus.valid1, addr: bus.addr1, data: bus.data1};

    // Reset also blocks grants so nothing is handshaken while state is cleared.
    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({r1.valid, r0.valid}),
        .advance (xfer),
        .hold    (bus.hold | rst),
        .gnt     (gnt),
        .rr_ptr  (unused_rr_ptr)
    );

    assign bus.ready0 = gnt[0];
    assign bus.ready1 = gnt[1];

    assign win   = gnt[1] ? r1 : r0;
    assign xfer  = (gnt != 2'b00) && win.valid;
    assign wr_ok = is_writable(win.addr);
    assign drop  = xfer && !wr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            we_q <= xfer && wr_ok;
            if (xfer && wr_ok) begin
                waddr_q <= win.addr;
                wdata_q <= win.data;
            end
            // A drop in the clear cycle counts as the first new drop.
            if (drop) begin
                err_q <= 1'b1;
                if (bus.err_clr) begin
                    cnt_q <= CNT_W'(1);
                end else if (!(&cnt_q)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
                cnt_q <= '0;
            end
        end
    end

    assign bus.rf_we    = we_q;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;
    assign bus.err      = err_q;
    assign bus.drop_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed + random bench for regfile_write_arbiter against a rule-level model.
// Ports: drives the interface master side, clk and rst.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    int   m_ptr;
    bit   m_err;
    int   m_cnt;
    bit   m_we;
    int   m_addr;
    int   m_data;
    int   last_g;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_err  = 0;
        m_cnt  = 0;
        m_we   = 0;
        m_addr = 0;
        m_data = 0;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_we"}, bus.rf_we, m_we);
        chk({tag, "_waddr"}, bus.rf_waddr, m_addr);
        chk({tag, "_wdata"}, bus.rf_wdata, m_data);
        chk({tag, "_err"}, bus.err, m_err);
        chk({tag, "_cnt"}, bus.drop_cnt, m_cnt);
    endtask

    // One clock: check readies mid-cycle, then model the edge and check outputs.
    task automatic tick();
        int g;
        int a;
        int d;
        @(negedge clk);
        g = -1;
        if (!bus.hold && !rst) begin
            if (bus.valid0 && bus.valid1) g = m_ptr;
            else if (bus.valid0) g = 0;
            else if (bus.valid1) g = 1;
        end
        chk("ready0", bus.ready0, g == 0);
        chk("ready1", bus.ready1, g == 1);
        last_g = g;
        @(posedge clk);
        #1;
        a = (g == 1) ? int'(bus.addr1) : int'(bus.addr0);
        d = (g == 1) ? int'(bus.data1) : int'(bus.data0);
        m_we = 0;
        if (bus.err_clr) begin
            m_err = 0;
            m_cnt = 0;
        end
        if (g >= 0) begin
            m_ptr = 1 - g;
            if (a < NUM_WRITABLE) begin
                m_we   = 1;
                m_addr = a;
                m_data = d;
            end else begin
                m_err = 1;
                m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            end
        end
        chk_outs("out");
    endtask

    initial begin
        rst         = 1'b1;
        bus.hold    = 1'b0;
        bus.valid0  = 1'b1;
        bus.addr0   = '0;
        bus.data0   = '0;
        bus.valid1  = 1'b1;
        bus.addr1   = '0;
        bus.data1   = '0;
        bus.err_clr = 1'b0;
        last_g      = -1;
        model_reset();

        #12;
        chk("rst_ready0", bus.ready0, 0);
        chk("rst_ready1", bus.ready1, 0);
        chk_outs("rst");
        bus.valid0 = 1'b0;
        bus.valid1 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: single write from requester 0
        bus.valid0 = 1'b1;
        bus.addr0  = 3'd2;
        bus.data0  = 10'h155;
        tick();
        chk("t1_we", bus.rf_we, 1);
        chk("t1_waddr", bus.rf_waddr, 2);
        chk("t1_wdata", bus.rf_wdata, 10'h155);
        bus.valid0 = 1'b0;

        // bring pointer back to requester 0
        bus.valid1 = 1'b1;
        bus.addr1  = 3'd1;
        bus.data1  = 10'h0aa;
        tick();

        // 2: continuous contention alternates 0,1,0,1
        bus.valid0 = 1'b1;
        bus.addr0  = 3'd0;
        bus.addr1  = 3'd1;
        for (int i = 0; i < 4; i++) begin
            bus.data0 = 10'($urandom);
            bus.data1 = 10'($urandom);
            tick();
            chk("t2_we", bus.rf_we, 1);
            chk("t2_waddr", bus.rf_waddr, i % 2);
        end
        bus.valid0 = 1'b0;
        bus.valid1 = 1'b0;
        tick();

        // 3: illegal writes, saturation, clear
        bus.valid1 = 1'b1;
        bus.addr1  = 3'd5;
        tick();
        chk("t3_we", bus.rf_we, 0);
        chk("t3_err", bus.err, 1);
        chk("t3_cnt1", bus.drop_cnt, 1);
        for (int i = 0; i < 299; i++) tick();
        chk("t3_sat", bus.drop_cnt, 255);
        bus.valid1  = 1'b0;
        bus.err_clr = 1'b1;
        tick();
        chk("t3_clr_err", bus.err, 0);
        chk("t3_clr_cnt", bus.drop_cnt, 0);
        bus.valid1 = 1'b1;
        bus.addr1  = 3'd4;
        tick();
        chk("t3_clrdrop", bus.drop_cnt, 1);
        bus.valid1  = 1'b0;
        bus.err_clr = 1'b0;
        tick();

        // 4: hold freezes grants
        bus.hold   = 1'b1;
        bus.valid0 = 1'b1;
        bus.valid1 = 1'b1;
        bus.addr0  = 3'd1;
        bus.addr1  = 3'd2;
        for (int i = 0; i < 3; i++) tick();
        bus.hold = 1'b0;
        tick();
        bus.valid0 = 1'b0;
        bus.valid1 = 1'b0;

        // 6: same address, pointer on requester 1
        bus.valid0 = 1'b1;
        bus.addr0  = 3'd0;
        tick();
        bus.valid1 = 1'b1;
        bus.addr0  = 3'd3;
        bus.data0  = 10'h001;
        bus.addr1  = 3'd3;
        bus.data1  = 10'h3ff;
        tick();
        chk("t6_first", bus.rf_wdata, 10'h3ff);
        bus.valid1 = 1'b0;
        tick();
        chk("t6_second", bus.rf_wdata, 10'h001);
        chk("t6_addr", bus.rf_waddr, 3);

        // 5: reset kills the pending output-stage write
        bus.addr0 = 3'd1;
        bus.data0 = 10'h2aa;
        tick();
        chk("t5_pre_we", bus.rf_we, 1);
        bus.valid1 = 1'b1;
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("t5_we", bus.rf_we, 0);
        chk("t5_ready0", bus.ready0, 0);
        chk("t5_ready1", bus.ready1, 0);
        chk_outs("t5");
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t5_ptr0", bus.ready0, 1);
        chk("t5_ptr1", bus.ready1, 0);
        tick();
        bus.valid0 = 1'b0;
        bus.valid1 = 1'b0;

        // random traffic; requesters keep payload stable until accepted
        last_g = -1;
        for (int i = 0; i < 400; i++) begin
            if (!bus.valid0 || last_g == 0) begin
                bus.valid0 = ($urandom % 4) != 0;
                bus.addr0  = 3'($urandom);
                bus.data0  = 10'($urandom);
            end
            if (!bus.valid1 || last_g == 1) begin
                bus.valid1 = ($urandom % 4) != 0;
                bus.addr1  = 3'($urandom);
                bus.data1  = 10'($urandom);
            end
            bus.hold    = ($urandom % 8) == 0;
            bus.err_clr = ($urandom % 16) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
